// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the external VRAM bus between the MPU port and the
// Renderer fetch port. Each access runs IDLE -> ACCESS -> ACK (-> TURN after
// a write). The Renderer has priority, but a streak counter guarantees the
// MPU a grant after MAX_REN_STREAK consecutive Renderer grants while it waits.
// Optional feature: define VRAM_ARB_WRITE_BUFFER_EN for a one-entry posted
// write buffer on the MPU port.
module vram_arbiter #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int WAIT_CYCLES    = 1,
  parameter int MAX_REN_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  _reset,
  input  logic                  mpu_req,
  input  logic                  mpu_wr,
  input  logic [1:0]            mpu_be,
  input  logic [ADDR_WIDTH-1:0] mpu_addr,
  input  logic [DATA_WIDTH-1:0] mpu_wdata,
  output logic [DATA_WIDTH-1:0] mpu_rdata,
  output logic                  mpu_ack,
  input  logic                  ren_req,
  input  logic [ADDR_WIDTH-1:0] ren_addr,
  output logic [DATA_WIDTH-1:0] ren_rdata,
  output logic                  ren_ack,
  output logic                  _vram_en,
  output logic                  _vram_rd,
  output logic                  _vram_wr,
  output logic [1:0]            _vram_be,
  output logic [ADDR_WIDTH-1:0] vram_addr,
  output logic [DATA_WIDTH-1:0] vram_data_out,
  output logic                  vram_data_oe,
  input  logic [DATA_WIDTH-1:0] vram_data_in
);

  localparam logic [2:0] LP_WAIT = 3'(WAIT_CYCLES);
  localparam logic [3:0] LP_MAX  = 4'(MAX_REN_STREAK);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2,
    S_TURN   = 2'd3
  } state_t;

  state_t                r_state;
  logic [2:0]            r_cnt;
  logic [3:0]            r_streak;
  logic                  r_owner_mpu;
  logic                  r_is_wr;
  logic                  r_en;
  logic                  r_rd;
  logic                  r_wr;
  logic [1:0]            r_be;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_oe;
  logic                  r_mpu_ack;
  logic                  r_ren_ack;
  logic [DATA_WIDTH-1:0] r_mpu_rdata;
  logic [DATA_WIDTH-1:0] r_ren_rdata;

  // MPU request as seen by the arbiter (either the live port or the buffer)
  logic                  w_mpu_live;
  logic                  w_mpu_pend;
  logic                  w_mpu_wr;
  logic [1:0]            w_mpu_be;
  logic [ADDR_WIDTH-1:0] w_mpu_addr;
  logic [DATA_WIDTH-1:0] w_mpu_wdata;
  logic                  w_grant_mpu;
  logic                  w_grant_ren;

  // The requester may still hold req during its ack cycle; that is not a new request.
  assign w_mpu_live = mpu_req & ~r_mpu_ack;

`ifdef VRAM_ARB_WRITE_BUFFER_EN
  logic                  r_buf_full;
  logic [1:0]            r_buf_be;
  logic [ADDR_WIDTH-1:0] r_buf_addr;
  logic [DATA_WIDTH-1:0] r_buf_wdata;
  logic                  w_buf_load;

  // Writes always go through the buffer; reads go direct only once it has drained.
  assign w_buf_load  = w_mpu_live & mpu_wr & ~r_buf_full;
  assign w_mpu_pend  = r_buf_full | (w_mpu_live & ~mpu_wr);
  assign w_mpu_wr    = r_buf_full;
  assign w_mpu_be    = r_buf_full ? r_buf_be   : mpu_be;
  assign w_mpu_addr  = r_buf_full ? r_buf_addr : mpu_addr;
  assign w_mpu_wdata = r_buf_wdata;
`else
  assign w_mpu_pend  = w_mpu_live;
  assign w_mpu_wr    = mpu_wr;
  assign w_mpu_be    = mpu_be;
  assign w_mpu_addr  = mpu_addr;
  assign w_mpu_wdata = mpu_wdata;
`endif

  // Renderer wins ties unless it has already used up its streak allowance.
  assign w_grant_mpu = (r_state == S_IDLE) & w_mpu_pend & (~ren_req | (r_streak == LP_MAX));
  assign w_grant_ren = (r_state == S_IDLE) & ren_req & ~w_grant_mpu;

  // Access sequencer: arbitration, bus strobes, data capture and acks.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_streak    <= '0;
      r_owner_mpu <= 1'b0;
      r_is_wr     <= 1'b0;
      r_en        <= 1'b1;
      r_rd        <= 1'b1;
      r_wr        <= 1'b1;
      r_be        <= 2'b11;
      r_addr      <= '0;
      r_dout      <= '0;
      r_oe        <= 1'b0;
      r_mpu_ack   <= 1'b0;
      r_ren_ack   <= 1'b0;
      r_mpu_rdata <= '0;
      r_ren_rdata <= '0;
`ifdef VRAM_ARB_WRITE_BUFFER_EN
      r_buf_full  <= 1'b0;
      r_buf_be    <= 2'b00;
      r_buf_addr  <= '0;
      r_buf_wdata <= '0;
`endif
    end else begin
      r_mpu_ack <= 1'b0;
      r_ren_ack <= 1'b0;
`ifdef VRAM_ARB_WRITE_BUFFER_EN
      if (w_buf_load) begin
        r_buf_full  <= 1'b1;
        r_buf_be    <= mpu_be;
        r_buf_addr  <= mpu_addr;
        r_buf_wdata <= mpu_wdata;
        r_mpu_ack   <= 1'b1;
      end
`endif
      unique case (r_state)
        S_IDLE: begin
          if (w_grant_mpu || w_grant_ren) begin
            r_state     <= S_ACCESS;
            r_cnt       <= '0;
            r_owner_mpu <= w_grant_mpu;
            r_is_wr     <= w_grant_mpu & w_mpu_wr;
            r_en        <= 1'b0;
            r_rd        <= w_grant_mpu & w_mpu_wr;
            r_wr        <= ~(w_grant_mpu & w_mpu_wr);
            r_be        <= w_grant_mpu ? ~w_mpu_be : 2'b00;
            r_addr      <= w_grant_mpu ? w_mpu_addr : ren_addr;
            r_oe        <= w_grant_mpu & w_mpu_wr;
            if (w_grant_mpu && w_mpu_wr) begin
              r_dout <= w_mpu_wdata;
            end
            if (w_grant_mpu || !w_mpu_pend) begin
              r_streak <= '0;
            end else if (r_streak != 4'hF) begin
              r_streak <= r_streak + 4'd1;
            end
          end
        end
        S_ACCESS: begin
          if (r_cnt == LP_WAIT) begin
            r_state <= S_ACK;
            r_en    <= 1'b1;
            r_rd    <= 1'b1;
            r_wr    <= 1'b1;
            r_be    <= 2'b11;
            r_oe    <= 1'b0;
            if (!r_is_wr) begin
              if (r_owner_mpu) begin
                r_mpu_rdata <= vram_data_in;
              end else begin
                r_ren_rdata <= vram_data_in;
              end
            end
            if (!r_owner_mpu) begin
              r_ren_ack <= 1'b1;
`ifdef VRAM_ARB_WRITE_BUFFER_EN
            end else if (!r_is_wr) begin
              r_mpu_ack <= 1'b1;
            end else begin
              r_buf_full <= 1'b0;
            end
`else
            end else begin
              r_mpu_ack <= 1'b1;
            end
`endif
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        S_ACK: begin
          r_state <= r_is_wr ? S_TURN : S_IDLE;
        end
        S_TURN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mpu_rdata     = r_mpu_rdata;
  assign mpu_ack       = r_mpu_ack;
  assign ren_rdata     = r_ren_rdata;
  assign ren_ack       = r_ren_ack;
  assign _vram_en      = r_en;
  assign _vram_rd      = r_rd;
  assign _vram_wr      = r_wr;
  assign _vram_be      = r_be;
  assign vram_addr     = r_addr;
  assign vram_data_out = r_dout;
  assign vram_data_oe  = r_oe;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus randomized traffic from both
// ports, checked against a word-level VRAM model and an MPU-side golden memory.
module tb_vram_arbiter;
  localparam int WAIT = 1;
  localparam int MAXS = 4;
`ifdef VRAM_ARB_WRITE_BUFFER_EN
  localparam int WR_LAT = 2;
`else
  localparam int WR_LAT = WAIT + 3;
`endif
  localparam int RD_LAT = WAIT + 3;

  logic        clk = 1'b0;
  logic        _reset;
  logic        mpu_req, mpu_wr, mpu_ack, ren_req, ren_ack;
  logic [1:0]  mpu_be;
  logic [15:0] mpu_addr, mpu_wdata, mpu_rdata, ren_addr, ren_rdata;
  logic        _vram_en, _vram_rd, _vram_wr, vram_data_oe;
  logic [1:0]  _vram_be;
  logic [15:0] vram_addr, vram_data_out;
  logic [15:0] vram_data_in = 16'h0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .WAIT_CYCLES(WAIT), .MAX_REN_STREAK(MAXS)) dut (
    .clk(clk), ._reset(_reset),
    .mpu_req(mpu_req), .mpu_wr(mpu_wr), .mpu_be(mpu_be), .mpu_addr(mpu_addr),
    .mpu_wdata(mpu_wdata), .mpu_rdata(mpu_rdata), .mpu_ack(mpu_ack),
    .ren_req(ren_req), .ren_addr(ren_addr), .ren_rdata(ren_rdata), .ren_ack(ren_ack),
    ._vram_en(_vram_en), ._vram_rd(_vram_rd), ._vram_wr(_vram_wr), ._vram_be(_vram_be),
    .vram_addr(vram_addr), .vram_data_out(vram_data_out), .vram_data_oe(vram_data_oe),
    .vram_data_in(vram_data_in)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Background contents of the VRAM before anything is written.
  function automatic logic [15:0] bg_word(input logic [15:0] a);
    return (a == 16'h1234) ? 16'hBEEF : (a ^ 16'h5A5A);
  endfunction

  // VRAM model: commits writes seen on the bus, presents data at the addressed word.
  logic [15:0] mem [0:65535];
  logic        mem_ready = 1'b0;
  always @(negedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 65536; i++) mem[i] <= bg_word(16'(i));
      mem_ready <= 1'b1;
    end else if (_reset && !_vram_en && !_vram_wr && vram_data_oe) begin
      if (!_vram_be[0]) mem[vram_addr][7:0]  <= vram_data_out[7:0];
      if (!_vram_be[1]) mem[vram_addr][15:8] <= vram_data_out[15:8];
    end
    vram_data_in <= mem[vram_addr];
  end

  // Bus monitor: logs each access {is_read, addr} and checks strobe length.
  logic [16:0] acc_q [$];
  int          mon_run = 0;
  always @(negedge clk) begin
    if (!_reset) begin
      mon_run = 0;
    end else if (!_vram_en) begin
      if (mon_run == 0) acc_q.push_back({~_vram_rd, vram_addr});
      mon_run++;
    end else if (mon_run != 0) begin
      chk("strobe_len", 32'(mon_run), 32'(WAIT + 1));
      mon_run = 0;
    end
  end

  task automatic mpu_op(input logic wr, input logic [1:0] be, input logic [15:0] addr,
                        input logic [15:0] wd, output logic [15:0] rd, output int lat);
    @(negedge clk);
    mpu_req = 1'b1; mpu_wr = wr; mpu_be = be; mpu_addr = addr; mpu_wdata = wd;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!mpu_ack && lat < 200);
    chk("mpu_ack_seen", 32'(mpu_ack), 32'd1);
    rd = mpu_rdata;
    mpu_req = 1'b0;
    lat = lat + 1;
  endtask

  task automatic ren_op(input logic [15:0] addr, output logic [15:0] rd, output int lat);
    @(negedge clk);
    ren_req = 1'b1; ren_addr = addr;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!ren_ack && lat < 200);
    chk("ren_ack_seen", 32'(ren_ack), 32'd1);
    rd = ren_rdata;
    ren_req = 1'b0;
    lat = lat + 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd, be_s, d_s, a_s, exp_w;
    int lat, cyc, rdlow, ackcnt, acklat, wrlow, oe_bad, rd_start, n0, t;
    int ren_before, mpu_done, after_ren;
    logic [16:0] exp_acc [6];

    _reset = 1'b0; mpu_req = 1'b0; mpu_wr = 1'b0; mpu_be = 2'b00; mpu_addr = 16'h0;
    mpu_wdata = 16'h0; ren_req = 1'b0; ren_addr = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_strobes", 32'({_vram_en, _vram_rd, _vram_wr, _vram_be}), 32'h1F);
    chk("rst_addr", 32'(vram_addr), 32'h0);
    chk("rst_dout", 32'(vram_data_out), 32'h0);
    chk("rst_rdata", 32'({mpu_rdata, ren_rdata}), 32'h0);
    _reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_outputs", 32'({_vram_en, _vram_rd, _vram_wr, _vram_be, vram_data_oe, mpu_ack, ren_ack}), 32'hF8);
    end

    // Renderer read of 0x1234
    ren_req = 1'b1; ren_addr = 16'h1234;
    cyc = 1; rdlow = 0; ackcnt = 0; acklat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); cyc++;
      if (!_vram_rd && !_vram_en) rdlow++;
      if (ren_ack) begin
        ackcnt++;
        if (acklat == 0) acklat = cyc;
        ren_req = 1'b0;
        chk("ren_rdata", 32'(ren_rdata), 32'hBEEF);
      end
    end
    chk("ren_lat", 32'(acklat), 32'(RD_LAT));
    chk("ren_ackcnt", 32'(ackcnt), 32'd1);
    chk("ren_rd_low", 32'(rdlow), 32'(WAIT + 1));
    chk("ren_rdata_hold", 32'(ren_rdata), 32'hBEEF);

    // MPU byte write 0x00AA to 0x0010, low byte only
    mpu_req = 1'b1; mpu_wr = 1'b1; mpu_be = 2'b01; mpu_addr = 16'h0010; mpu_wdata = 16'h00AA;
    cyc = 1; ackcnt = 0; acklat = 0; wrlow = 0; oe_bad = 0; rd_start = 0;
    be_s = 16'hFFFF; d_s = 16'h0; a_s = 16'h0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk); cyc++;
      if (!_vram_wr) begin
        wrlow++; be_s = 16'(_vram_be); d_s = vram_data_out; a_s = vram_addr;
        if (!vram_data_oe) oe_bad++;
      end
      if (vram_data_oe && _vram_wr) oe_bad++;
      if (!_vram_rd && rd_start == 0) rd_start = cyc;
      if (ren_ack) ren_req = 1'b0;
      if (mpu_ack) begin
        ackcnt++;
        if (acklat == 0) acklat = cyc;
        mpu_req = 1'b0;
`ifndef VRAM_ARB_WRITE_BUFFER_EN
        ren_req = 1'b1; ren_addr = 16'h8001;
`endif
      end
    end
    chk("wr_ack_lat", 32'(acklat), 32'(WR_LAT));
    chk("wr_ackcnt", 32'(ackcnt), 32'd1);
    chk("wr_low", 32'(wrlow), 32'(WAIT + 1));
    chk("wr_be", 32'(be_s), 32'h2);
    chk("wr_data", 32'(d_s), 32'h00AA);
    chk("wr_addr", 32'(a_s), 32'h0010);
    chk("wr_oe_window", 32'(oe_bad), 32'd0);
    exp_w = {bg_word(16'h0010) >> 8, 8'hAA};
    chk("wr_mem", 32'(mem[16'h0010]), 32'(exp_w));
`ifndef VRAM_ARB_WRITE_BUFFER_EN
    chk("turn_then_read", 32'(rd_start), 32'(WR_LAT + 3));
`endif

    // Write then read of the same word: write must reach the bus first
    n0 = acc_q.size();
    mpu_op(1'b1, 2'b11, 16'h0050, 16'h1357, rd, lat);
    chk("wb_wr_lat", 32'(lat), 32'(WR_LAT));
    mpu_op(1'b0, 2'b11, 16'h0050, 16'h0000, rd, lat);
    chk("wb_rd_data", 32'(rd), 32'h1357);
    chk("wb_acc_cnt", 32'(acc_q.size() - n0), 32'd2);
    if (acc_q.size() >= n0 + 2) begin
      chk("wb_first_is_wr", 32'(acc_q[n0]), 32'({1'b0, 16'h0050}));
      chk("wb_second_is_rd", 32'(acc_q[n0 + 1]), 32'({1'b1, 16'h0050}));
    end

    // Starvation limit: continuous Renderer traffic, MPU raised
    @(negedge clk);
    ren_req = 1'b1; ren_addr = 16'h0100;
    t = 0;
    while (!ren_ack && t < 50) begin @(negedge clk); t++; end
    chk("strk_first_ack", 32'(ren_ack), 32'd1);
    mpu_req = 1'b1; mpu_wr = 1'b0; mpu_be = 2'b11; mpu_addr = 16'h0200;
    n0 = acc_q.size(); ren_before = 0; mpu_done = 0; after_ren = 0; t = 0;
    while (t < 200 && after_ren == 0) begin
      @(negedge clk); t++;
      if (mpu_ack) begin
        mpu_done = 1; mpu_req = 1'b0;
        chk("strk_mpu_rd", 32'(mpu_rdata), 32'(bg_word(16'h0200)));
      end
      if (ren_ack) begin
        if (mpu_done != 0) begin after_ren = 1; ren_req = 1'b0; end
        else ren_before++;
      end
    end
    ren_req = 1'b0;
    chk("strk_ren_before", 32'(ren_before), 32'(MAXS));
    chk("strk_resumed", 32'(after_ren), 32'd1);
    for (int k = 0; k < 6; k++) exp_acc[k] = {1'b1, 16'h0100};
    exp_acc[MAXS] = {1'b1, 16'h0200};
    for (int k = 0; k < 6; k++) begin
      if (acc_q.size() > n0 + k) chk("strk_order", 32'(acc_q[n0 + k]), 32'(exp_acc[k]));
      else chk("strk_order_missing", 32'(acc_q.size()), 32'(n0 + k + 1));
    end

    // Reset in the second ACCESS cycle of a write
    @(negedge clk);
    mpu_req = 1'b1; mpu_wr = 1'b1; mpu_be = 2'b11; mpu_addr = 16'h0030; mpu_wdata = 16'h9999;
    t = 0;
    while (_vram_wr && t < 20) begin
      @(negedge clk); t++;
      if (mpu_ack) mpu_req = 1'b0;
    end
    chk("rst_wr_started", 32'(_vram_wr), 32'd0);
    @(negedge clk);
    chk("rst_wr_second", 32'(_vram_wr), 32'd0);
    ackcnt = 0;
    #2 _reset = 1'b0;
    #1;
    chk("rst_async_strobes", 32'({_vram_en, _vram_rd, _vram_wr, _vram_be, vram_data_oe}), 32'h3E);
    mpu_req = 1'b0;
    for (int i = 0; i < 2; i++) begin @(negedge clk); if (mpu_ack) ackcnt++; end
    _reset = 1'b1;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (mpu_ack || ren_ack) ackcnt++; end
    chk("rst_no_ack", 32'(ackcnt), 32'd0);
    ren_op(16'h8010, rd, lat);
    chk("rst_fresh_rd", 32'(rd), 32'(bg_word(16'h8010)));
    chk("rst_fresh_lat", 32'(lat), 32'(RD_LAT));

    // Randomized concurrent traffic
    fork
      begin : p_mpu
        logic [15:0] g [0:15];
        logic [15:0] r, wd, a;
        logic [1:0]  be;
        logic        wr;
        int          l;
        for (int i = 0; i < 16; i++) g[i] = bg_word(16'(16'h0040 + i));
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          wr = 1'($urandom_range(0, 1));
          be = 2'($urandom_range(1, 3));
          a  = 16'(16'h0040 + $urandom_range(0, 15));
          wd = 16'($urandom);
          mpu_op(wr, be, a, wd, r, l);
          if (wr) begin
            if (be[0]) g[a[3:0]][7:0]  = wd[7:0];
            if (be[1]) g[a[3:0]][15:8] = wd[15:8];
          end else begin
            chk("rand_mpu_rd", 32'(r), 32'(g[a[3:0]]));
          end
        end
      end
      begin : p_ren
        logic [15:0] r, a;
        int          l;
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          a = 16'(16'h8000 + $urandom_range(0, 255));
          ren_op(a, r, l);
          chk("rand_ren_rd", 32'(r), 32'(bg_word(a)));
        end
      end
    join

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
